// File: rtl/xor_chain_pipe.sv
// xor_chain_pipe: a^b followed by DEPTH XOR mixing stages, register slice every PIPE_EVERY stages, valid/ready both sides.
// Optional XOR_CHAIN_PIPE_PARITY_EN adds z_par = ^a ^ ^b carried alongside the data.
module xor_chain_pipe #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 100,
  parameter int PIPE_EVERY = 25,
  parameter int MODE       = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
`ifdef XOR_CHAIN_PIPE_PARITY_EN
  output logic             z_par,
`endif
  output logic [CNT_W-1:0] done_cnt
);
  localparam int L = (DEPTH + PIPE_EVERY - 1) / PIPE_EVERY;
  function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] x, input int n);
    logic [WIDTH-1:0] t;
    t = x;
    for (int k = 0; k < PIPE_EVERY; k++)
      if (k < n) t = t ^ ((MODE == 0) ? t : {t[WIDTH-2:0], t[WIDTH-1]});
    return t;
  endfunction
  logic [WIDTH-1:0] d [L];
  logic [L-1:0] v, ld;
`ifdef XOR_CHAIN_PIPE_PARITY_EN
  logic [L-1:0] p;
`endif
  for (genvar j = 0; j < L; j++) begin : g_slice
    localparam int N = (((j + 1) * PIPE_EVERY > DEPTH) ? DEPTH : (j + 1) * PIPE_EVERY) - j * PIPE_EVERY;
    logic [WIDTH-1:0] src, dr;
    logic vin, vr;
    if (j == 0) begin : g_head
      assign src = a ^ b;
      assign vin = in_valid;
    end else begin : g_body
      assign src = d[j-1];
      assign vin = v[j-1];
    end
    // Unrolled form of !v[j] | ld[j+1]: a slice can load if the output drains or any bubble sits at or after it.
    assign ld[j] = out_ready | ~&v[L-1:j];
    assign v[j]  = vr;
    assign d[j]  = dr;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        vr <= 1'b0;
        dr <= '0;
      end else if (ld[j]) begin
        vr <= vin;
        if (vin) dr <= mix(src, N);
      end
`ifdef XOR_CHAIN_PIPE_PARITY_EN
    logic psrc, pr;
    if (j == 0) begin : g_phead
      assign psrc = ^a ^ ^b;
    end else begin : g_pbody
      assign psrc = p[j-1];
    end
    assign p[j] = pr;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pr <= 1'b0;
      else if (ld[j] && vin) pr <= psrc;
`endif
  end
  assign in_ready  = ld[0];
  assign out_valid = v[L-1];
  assign z         = d[L-1];
`ifdef XOR_CHAIN_PIPE_PARITY_EN
  assign z_par = p[L-1];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 1'b1;
endmodule

// File: tb/tb_xor_chain_pipe.sv
// tb_xor_chain_pipe: scoreboard bench for xor_chain_pipe (MODE=1 short chain and MODE=0 long chain).
module tb_xor_chain_pipe;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [7:0] a = 0, b = 0, z;
  logic [15:0] done_cnt;
  logic in_valid1 = 0, out_ready1 = 1, in_ready1, out_valid1;
  logic [7:0] a1 = 0, b1 = 0, z1;
  logic [15:0] done_cnt1;
`ifdef XOR_CHAIN_PIPE_PARITY_EN
  logic z_par, z_par1;
`endif
  int n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  xor_chain_pipe #(.WIDTH(8), .DEPTH(4), .PIPE_EVERY(2), .MODE(1), .CNT_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .z(z),
`ifdef XOR_CHAIN_PIPE_PARITY_EN
    .z_par(z_par),
`endif
    .done_cnt(done_cnt));

  xor_chain_pipe #(.WIDTH(8), .DEPTH(100), .PIPE_EVERY(25), .MODE(0), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .z(z1),
`ifdef XOR_CHAIN_PIPE_PARITY_EN
    .z_par(z_par1),
`endif
    .done_cnt(done_cnt1));

  // Polynomial view: z = t * (1+x)^n mod x^8-1; C(n,e) is odd iff e's bits are a subset of n's (Lucas).
  function automatic logic [7:0] ref_mix(input logic [7:0] t, input int n);
    logic [7:0] r;
    int s;
    r = 0;
    for (int e = 0; e <= n; e++)
      if ((e & n) == e) begin
        s = e % 8;
        r = r ^ ((t << s) | (t >> (8 - s)));
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib, input logic ordy);
    logic [8:0] e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    if (in_valid && in_ready) begin
      q.push_back({^ia ^ ^ib, ref_mix(ia ^ ib, 4)});
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) check("out_without_accept", out_valid, 0);
      else begin
        e = q.pop_front();
        check("z", z, e[7:0]);
`ifdef XOR_CHAIN_PIPE_PARITY_EN
        check("z_par", z_par, e[8]);
`endif
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, lat, n1;
    logic [7:0] zh;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_done_cnt", done_cnt, 0);
    reset_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);

    step(1, 8'h01, 8'h00, 1);
    step(0, 0, 0, 1);
    check("lat_cycle1_invalid", out_valid, 0);
    step(0, 0, 0, 1);
    check("lat_cycle2_valid", out_valid, 1);
    check("single_z", z, 8'h11);
    step(0, 0, 0, 1);
    check("single_done_cnt", done_cnt, 1);

    step(1, 8'hF0, 8'h0F, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("allones_z", z, 8'h00);
`ifdef XOR_CHAIN_PIPE_PARITY_EN
    check("allones_par", z_par, 0);
`endif
    step(0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(1, 8'h01 << i, 8'h00, 1);
    repeat (3) step(0, 0, 0, 1);
    check("b2b_done_cnt", done_cnt, 6);
    check("b2b_queue_empty", q.size(), 0);

    acc0 = n_acc;
    step(1, 8'h01, 8'h00, 0);
    step(1, 8'h80, 8'h00, 0);
    zh = z;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'($urandom), 8'($urandom), 0);
      check("stall_z_hold", z, ref_mix(8'h01, 4));
    end
    check("stall_accepts", n_acc - acc0, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    repeat (4) step(0, 0, 0, 1);
    check("stall_drained", q.size(), 0);
    check("stall_done_cnt", done_cnt, n_out);
    check("stall_no_dup", n_out, 8);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    repeat (4) step(0, 0, 0, 1);
    check("rand_drained", q.size(), 0);
    check("rand_done_cnt", done_cnt, 16'(n_out));

    @(negedge clk);
    in_valid1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
    #1;
    check("m0_in_ready", in_ready1, 1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid1 = 0;
      lat++;
      #1;
    end while (!out_valid1 && lat < 20);
    check("m0_latency", lat, 4);
    check("m0_z_first", z1, 0);
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid1 = (i < 10); a1 = 8'($urandom); b1 = 8'($urandom);
      #1;
      if (out_valid1) begin
        n1++;
        check("m0_z", z1, 0);
      end
    end
    check("m0_count", n1, 10);
    check("m0_done_cnt", done_cnt1, 11);

    step(1, 8'h03, 8'h00, 0);
    step(1, 8'h05, 8'h00, 0);
    #2 reset_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_z", z, 0);
    check("arst_done_cnt", done_cnt, 0);
    check("arst_m0_done_cnt", done_cnt1, 0);
    q.delete();
    n_out = 0;
    in_valid = 0;
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      check("no_stale_out", out_valid, 0);
    end
    check("post_rst_done_cnt", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
